// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Address width, default geometry and the fetch state encoding.
package inst_fetch_pkg;

  localparam int ADDR_W        = 32;
  localparam int MEM_WORDS_DEF = 64;
  localparam int RESET_PC_DEF  = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational fetch address selection: redirect, stall hold, or sequential
// increment, with every address kept inside the instruction memory.
module fetch_pc_gen
  import inst_fetch_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] req_pc_i,
  input  logic              run_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [ADDR_W-1:0] pc_next_o
);

  localparam logic [ADDR_W-1:0] WORDS = ADDR_W'(MEM_WORDS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_WORDS - 1);

  logic [ADDR_W-1:0] target_mod;
  logic [ADDR_W-1:0] target_inc;
  logic [ADDR_W-1:0] pc_inc;

  assign target_mod = redirect_target_i % WORDS;
  assign target_inc = (target_mod == LAST) ? '0 : target_mod + 1'b1;
  assign pc_inc     = (pc_i == LAST) ? '0 : pc_i + 1'b1;

  // Redirect outranks stall; stall only matters while an instruction is shown.
  always_comb begin
    mem_address_o = pc_i;
    pc_next_o     = pc_inc;
    if (redirect_i) begin
      mem_address_o = target_mod;
      pc_next_o     = target_inc;
    end else if (stall_i && run_i) begin
      mem_address_o = req_pc_i;
      pc_next_o     = pc_i;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit driving a registered-read instruction memory.
// Presents one instruction per cycle, supports stall hold and redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int RESET_PC  = RESET_PC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  output logic [ADDR_W-1:0] mem_address_o,
  input  logic [ADDR_W-1:0] mem_instruction_i,
  output logic [ADDR_W-1:0] instruction_o,
  output logic [ADDR_W-1:0] pc_out_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] fetch_count_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] fetch_count_q, fetch_count_d;
  fetch_state_e      state_q, state_d;
  logic              accept;

  fetch_pc_gen #(
    .MEM_WORDS(MEM_WORDS)
  ) u_pc_gen (
    .pc_i              (pc_q),
    .req_pc_i          (req_pc_q),
    .run_i             (state_q == RUN),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .mem_address_o     (mem_address_o),
    .pc_next_o         (pc_d)
  );

  assign valid_o       = (state_q == RUN) && !redirect_i;
  assign accept        = valid_o && !stall_i;
  assign instruction_o = mem_instruction_i;
  assign pc_out_o      = req_pc_q;
  assign fetch_count_o = fetch_count_q;

  // The address sent to memory this cycle is exactly what is in flight next.
  always_comb begin
    req_pc_d      = mem_address_o;
    state_d       = RUN;
    fetch_count_d = fetch_count_q;
    if (accept) begin
      fetch_count_d = fetch_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q          <= ADDR_W'(RESET_PC);
      req_pc_q      <= '0;
      state_q       <= IDLE;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a behavioural fetch-stream model checked
// every cycle, plus literal expectations at key points of the scenario.
module tb_inst_fetch;

  localparam int WORDS = 64;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_target_i = '0;
  logic [31:0] mem_address_o;
  logic [31:0] mem_instruction_i = '0;
  logic [31:0] instruction_o;
  logic [31:0] pc_out_o;
  logic        valid_o;
  logic [31:0] fetch_count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [WORDS];

  inst_fetch #(.MEM_WORDS(WORDS), .RESET_PC(0)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .mem_address_o     (mem_address_o),
    .mem_instruction_i (mem_instruction_i),
    .instruction_o     (instruction_o),
    .pc_out_o          (pc_out_o),
    .valid_o           (valid_o),
    .fetch_count_o     (fetch_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h1000_0000 + i;
  end

  always @(posedge clk_i) mem_instruction_i <= mem[mem_address_o[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: whether an instruction is being shown, which word, what comes next.
  logic        m_live;
  logic [31:0] m_pc, m_next, m_cnt;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_live <= 1'b0;
      m_pc   <= 32'd0;
      m_next <= 32'd0;
      m_cnt  <= 32'd0;
    end else begin
      if (m_live && !redirect_i && !stall_i) m_cnt <= m_cnt + 1;
      if (redirect_i) begin
        m_pc   <= redirect_target_i % WORDS;
        m_next <= ((redirect_target_i % WORDS) + 1) % WORDS;
        m_live <= 1'b1;
      end else if (!(m_live && stall_i)) begin
        m_pc   <= m_next;
        m_next <= (m_next + 1) % WORDS;
        m_live <= 1'b1;
      end
    end
  end

  always @(negedge clk_i) begin
    logic [31:0] exp_addr;
    logic        exp_valid;
    exp_valid = m_live && !redirect_i;
    if (redirect_i)             exp_addr = redirect_target_i % WORDS;
    else if (m_live && stall_i) exp_addr = m_pc;
    else                        exp_addr = m_next;
    chk("model_valid", {31'd0, valid_o}, {31'd0, exp_valid});
    chk("model_pc_out", pc_out_o, m_pc);
    chk("model_mem_address", mem_address_o, exp_addr);
    chk("model_fetch_count", fetch_count_o, m_cnt);
    if (exp_valid) chk("model_instruction", instruction_o, 32'h1000_0000 + m_pc);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic lit(input string name, input logic v, input logic [31:0] pc,
                     input logic [31:0] ins);
    #1;
    chk({name, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    if (v) begin
      chk({name, "_pc"}, pc_out_o, pc);
      chk({name, "_instr"}, instruction_o, ins);
    end
  endtask

  initial begin
    tick(); tick();
    lit("reset", 1'b0, 32'd0, 32'd0);
    chk("reset_pc_out", pc_out_o, 32'd0);
    chk("reset_count", fetch_count_o, 32'd0);
    chk("reset_mem_addr", mem_address_o, 32'd0);
    rst_ni = 1'b1;

    for (int c = 1; c <= 4; c++) begin
      tick();
      lit("seq", 1'b1, 32'(c - 1), 32'h1000_0000 + 32'(c - 1));
    end
    tick();                                  // cycle 5: pc 4
    chk("count_after_4", fetch_count_o, 32'd4);
    tick();                                  // cycle 6: pc 5
    stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      lit("stall", 1'b1, 32'd5, 32'h1000_0005);
      chk("stall_count", fetch_count_o, 32'd5);
      tick();
    end
    stall_i = 1'b0;                          // cycle 9: pc 5 accepted
    lit("stall_rel", 1'b1, 32'd5, 32'h1000_0005);
    tick();
    lit("resume", 1'b1, 32'd6, 32'h1000_0006);
    chk("resume_count", fetch_count_o, 32'd6);
    tick();                                  // cycle 11: pc 7
    redirect_i = 1'b1; redirect_target_i = 32'd40;
    lit("redir_squash", 1'b0, 32'd0, 32'd0);
    chk("redir_mem_addr", mem_address_o, 32'd40);
    tick();
    redirect_i = 1'b0;
    lit("redir_40", 1'b1, 32'd40, 32'h1000_0028);
    tick();
    lit("redir_41", 1'b1, 32'd41, 32'h1000_0029);
    redirect_i = 1'b1; redirect_target_i = 32'd62;
    tick();
    redirect_i = 1'b0;
    lit("wrap_62", 1'b1, 32'd62, 32'h1000_003E);
    tick();
    lit("wrap_63", 1'b1, 32'd63, 32'h1000_003F);
    tick();
    lit("wrap_0", 1'b1, 32'd0, 32'h1000_0000);
    redirect_i = 1'b1; redirect_target_i = 32'd70;
    tick();
    redirect_i = 1'b0;
    lit("mod_70", 1'b1, 32'd6, 32'h1000_0006);
    redirect_i = 1'b1; stall_i = 1'b1; redirect_target_i = 32'd10;
    lit("redir_stall", 1'b0, 32'd0, 32'd0);
    tick();
    redirect_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      lit("rs_hold", 1'b1, 32'd10, 32'h1000_000A);
      tick();
    end
    stall_i = 1'b0;
    tick();
    lit("rs_next", 1'b1, 32'd11, 32'h1000_000B);
    redirect_i = 1'b1; redirect_target_i = 32'd20;
    tick();
    redirect_i = 1'b0; stall_i = 1'b1;
    lit("pre_rst", 1'b1, 32'd20, 32'h1000_0014);
    tick();
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_count", fetch_count_o, 32'd0);
    chk("rst_mem_addr", mem_address_o, 32'd0);
    tick();
    rst_ni = 1'b1; stall_i = 1'b0;
    lit("post_rst_idle", 1'b0, 32'd0, 32'd0);
    tick();
    lit("post_rst_0", 1'b1, 32'd0, 32'h1000_0000);
    tick();
    lit("post_rst_1", 1'b1, 32'd1, 32'h1000_0001);
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
